mux16_scan_ctrl: RTL and testbench

//  Sequencer upstream/downstream of the 16:1 bit mux tree.

---
 rtl/mux_scan_pkg.sv | 16 +
 rtl/mux16_scan_ctrl.sv | 86 ++++++++
 tb/tb_mux16_scan_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 16:1 mux scan sequencer.
package mux_scan_pkg;

    // Scan sequencer states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_HOLD
    } scan_state_t;

    localparam int unsigned DEF_N_CH  = 16;
    localparam int unsigned DEF_SEL_W = $clog2(DEF_N_CH);
    localparam int unsigned SETTLE_W  = 4;

endpackage

// File: rtl/mux16_scan_ctrl.sv
// Steps the mux-tree select through every channel, captures the returned bit
// per channel into a snapshot, and offers the snapshot over valid/ready.
module mux16_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned N_CH   = 16,
    parameter int unsigned SEL_W  = $clog2(N_CH),
    parameter int unsigned SETTLE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [SEL_W-1:0] sel,
    input  logic             mux_out,
    output logic             busy,
    output logic [N_CH-1:0]  snap_data,
    output logic             snap_valid,
    input  logic             snap_ready,
    output logic             overrun,
    input  logic             clr_ovr
);

    localparam logic [SEL_W-1:0]    SEL_LAST  = SEL_W'(N_CH - 1);
    localparam logic [SETTLE_W-1:0] WAIT_LAST = SETTLE_W'(SETTLE - 1);

    scan_state_t         state;
    scan_state_t         state_nxt;
    logic [SETTLE_W-1:0] wait_cnt;
    logic                accept;

    assign accept     = (state == ST_IDLE) && start;
    assign busy       = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign snap_valid = (state == ST_HOLD);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode; SETTLE==0 skips the settle state entirely
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (start) state_nxt = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
            ST_SETTLE: if (wait_cnt == WAIT_LAST) state_nxt = ST_SAMPLE;
            ST_SAMPLE: begin
                if (sel == SEL_LAST)   state_nxt = ST_HOLD;
                else if (SETTLE != 0)  state_nxt = ST_SETTLE;
            end
            ST_HOLD:   if (snap_ready) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Select and settle-wait counters; sel holds at the last channel, never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel      <= '0;
            wait_cnt <= '0;
        end else if (accept) begin
            sel      <= '0;
            wait_cnt <= '0;
        end else if (state == ST_SETTLE) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else if (state == ST_SAMPLE && sel != SEL_LAST) begin
            sel      <= sel + 1'b1;
            wait_cnt <= '0;
        end
    end

    // Snapshot capture; mux_out is only looked at in SAMPLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  snap_data      <= '0;
        else if (accept)             snap_data      <= '0;
        else if (state == ST_SAMPLE) snap_data[sel] <= mux_out;
    end

    // Sticky overrun: a set in the same cycle as a clear takes priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          overrun <= 1'b0;
        else if (start && state != ST_IDLE)  overrun <= 1'b1;
        else if (clr_ovr)                    overrun <= 1'b0;
    end

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// Directed bench for mux16_scan_ctrl: one instance with SETTLE=0, one with SETTLE=2,
// each loaded by a 16:1 mux of a driven input word.
module tb_mux16_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start_a = 1'b0, ready_a = 1'b0, clr_a = 1'b0;
    logic [3:0]  sel_a;
    logic        mux_a, busy_a, valid_a, ovr_a;
    logic [15:0] data_a;
    logic [15:0] in_a = 16'h0000;

    logic        start_b = 1'b0, ready_b = 1'b0, clr_b = 1'b0;
    logic [3:0]  sel_b;
    logic        mux_b, busy_b, valid_b, ovr_b;
    logic [15:0] data_b;
    logic [15:0] in_b = 16'h0000;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign mux_a = in_a[sel_a];
    assign mux_b = in_b[sel_b];

    mux16_scan_ctrl #(.N_CH(16), .SEL_W(4), .SETTLE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .sel(sel_a), .mux_out(mux_a),
        .busy(busy_a), .snap_data(data_a), .snap_valid(valid_a), .snap_ready(ready_a),
        .overrun(ovr_a), .clr_ovr(clr_a)
    );

    mux16_scan_ctrl #(.N_CH(16), .SEL_W(4), .SETTLE(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .sel(sel_b), .mux_out(mux_b),
        .busy(busy_b), .snap_data(data_b), .snap_valid(valid_b), .snap_ready(ready_b),
        .overrun(ovr_b), .clr_ovr(clr_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        n_cmp++; if (sel_a !== 4'd0)     begin n_err++; $display("FAIL reset_sel got=%0d exp=0", sel_a); end
        n_cmp++; if (busy_a !== 1'b0)    begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
        n_cmp++; if (data_a !== 16'h0)   begin n_err++; $display("FAIL reset_data got=%h exp=0000", data_a); end
        n_cmp++; if (valid_a !== 1'b0)   begin n_err++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
        n_cmp++; if (ovr_a !== 1'b0)     begin n_err++; $display("FAIL reset_overrun got=%b exp=0", ovr_a); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_scan_settle0();
        in_a = 16'hA5C3;
        ready_a = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 16; k++) begin
            n_cmp++; if (sel_a !== 4'(k)) begin n_err++; $display("FAIL s0_sel step=%0d got=%0d exp=%0d", k, sel_a, k); end
            n_cmp++; if (busy_a !== 1'b1 || valid_a !== 1'b0)
                begin n_err++; $display("FAIL s0_busy step=%0d busy=%b valid=%b exp busy=1 valid=0", k, busy_a, valid_a); end
            tick();
        end
        n_cmp++; if (valid_a !== 1'b1)    begin n_err++; $display("FAIL s0_valid got=%b exp=1", valid_a); end
        n_cmp++; if (busy_a !== 1'b0)     begin n_err++; $display("FAIL s0_busy_end got=%b exp=0", busy_a); end
        n_cmp++; if (data_a !== 16'hA5C3) begin n_err++; $display("FAIL s0_data got=%h exp=a5c3", data_a); end
    endtask

    task automatic test_hold_stall();
        in_a = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++; if (valid_a !== 1'b1 || data_a !== 16'hA5C3)
                begin n_err++; $display("FAIL hold_stable cyc=%0d valid=%b data=%h exp valid=1 data=a5c3", i, valid_a, data_a); end
        end
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        n_cmp++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL hold_release got=%b exp=0", valid_a); end
        tick();
        n_cmp++; if (valid_a !== 1'b0 || busy_a !== 1'b0)
            begin n_err++; $display("FAIL hold_idle valid=%b busy=%b exp 0 0", valid_a, busy_a); end
        in_a = 16'hA5C3;
    endtask

    task automatic test_scan_settle2();
        in_b = 16'h0001;
        ready_b = 1'b0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 3; j++) begin
                n_cmp++; if (sel_b !== 4'(k) || valid_b !== 1'b0 || busy_b !== 1'b1)
                    begin n_err++; $display("FAIL s2_step ch=%0d sub=%0d sel=%0d valid=%b busy=%b exp sel=%0d valid=0 busy=1", k, j, sel_b, valid_b, busy_b, k); end
                tick();
            end
        end
        n_cmp++; if (valid_b !== 1'b1)    begin n_err++; $display("FAIL s2_valid got=%b exp=1", valid_b); end
        n_cmp++; if (data_b !== 16'h0001) begin n_err++; $display("FAIL s2_data got=%h exp=0001", data_b); end
        ready_b = 1'b1;
        tick();
        ready_b = 1'b0;
        n_cmp++; if (valid_b !== 1'b0) begin n_err++; $display("FAIL s2_release got=%b exp=0", valid_b); end
    endtask

    task automatic test_overrun();
        bit seen;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (7) tick();
        n_cmp++; if (sel_a !== 4'd7) begin n_err++; $display("FAIL ovr_presel got=%0d exp=7", sel_a); end
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n_cmp++; if (ovr_a !== 1'b1) begin n_err++; $display("FAIL ovr_set got=%b exp=1", ovr_a); end
        n_cmp++; if (sel_a !== 4'd8) begin n_err++; $display("FAIL ovr_no_restart sel=%0d exp=8", sel_a); end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (valid_a === 1'b1) seen = 1'b1;
            else tick();
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL ovr_timeout valid=%b exp=1", valid_a); end
        n_cmp++; if (data_a !== 16'hA5C3) begin n_err++; $display("FAIL ovr_data got=%h exp=a5c3", data_a); end
        // clear and set in the same cycle, during the HOLD transfer: set must win
        clr_a = 1'b1; start_a = 1'b1; ready_a = 1'b1;
        tick();
        start_a = 1'b0; ready_a = 1'b0;
        n_cmp++; if (ovr_a !== 1'b1) begin n_err++; $display("FAIL ovr_set_wins got=%b exp=1", ovr_a); end
        n_cmp++; if (valid_a !== 1'b0 || busy_a !== 1'b0)
            begin n_err++; $display("FAIL ovr_hold_start_ignored valid=%b busy=%b exp 0 0", valid_a, busy_a); end
        tick();
        clr_a = 1'b0;
        n_cmp++; if (ovr_a !== 1'b0) begin n_err++; $display("FAIL ovr_clear got=%b exp=0", ovr_a); end
    endtask

    task automatic test_reset_mid();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (9) tick();
        n_cmp++; if (sel_a !== 4'd9) begin n_err++; $display("FAIL rst_presel got=%0d exp=9", sel_a); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (sel_a !== 4'd0 || busy_a !== 1'b0 || valid_a !== 1'b0 || data_a !== 16'h0 || ovr_a !== 1'b0)
            begin n_err++; $display("FAIL rst_async sel=%0d busy=%b valid=%b data=%h ovr=%b exp all 0", sel_a, busy_a, valid_a, data_a, ovr_a); end
        tick();
        rst_n = 1'b1;
        tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (15) tick();
        n_cmp++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL rst_early_valid got=%b exp=0", valid_a); end
        tick();
        n_cmp++; if (valid_a !== 1'b1 || data_a !== 16'hA5C3)
            begin n_err++; $display("FAIL rst_rescan valid=%b data=%h exp valid=1 data=a5c3", valid_a, data_a); end
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
    endtask

    task automatic test_back_to_back();
        int nvalid;
        ready_a = 1'b1;
        start_a = 1'b1;
        tick();
        nvalid = 0;
        for (int c = 1; c <= 54; c++) begin
            tick();
            n_cmp++; if (valid_a !== ((c % 18) == 16) || busy_a !== ((c % 18) < 16))
                begin n_err++; $display("FAIL b2b_cyc c=%0d valid=%b busy=%b exp valid=%b busy=%b", c, valid_a, busy_a, ((c % 18) == 16), ((c % 18) < 16)); end
            if (valid_a === 1'b1) begin
                nvalid++;
                n_cmp++; if (data_a !== 16'hA5C3) begin n_err++; $display("FAIL b2b_data c=%0d got=%h exp=a5c3", c, data_a); end
            end
        end
        n_cmp++; if (nvalid !== 3) begin n_err++; $display("FAIL b2b_count got=%0d exp=3", nvalid); end
        n_cmp++; if (ovr_a !== 1'b1) begin n_err++; $display("FAIL b2b_overrun got=%b exp=1", ovr_a); end
        start_a = 1'b0;
        repeat (20) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout sim_time=%0t limit=200000", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_scan_settle0();
        test_hold_stall();
        test_scan_settle2();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
